uart_rx_ctrl: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/uart_rx_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-controller state encoding and data-width limits
// used by the receiver, transmitter and their controllers.
package uart_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        BREAK = 2'd2
    } uart_rx_ctrl_state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    function automatic bit data_bits_legal(input int bits);
        return (bits >= DATA_BITS_MIN) && (bits <= DATA_BITS_MAX);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head word, occupancy level and flush.
// A pop is accepted only when non-empty; a push only when not full or popping in the same cycle.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [Width-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(Depth+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [Width-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic [PtrW-1:0]  rd_next;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (level_q == '0);
    assign full  = (level_q == LvlW'(Depth));

    always_comb begin
        rd_next  = rd_ptr_q + PtrW'(1);
        pop_ok   = pop && !empty && !flush;
        push_ok  = push && (!full || pop_ok) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (pop_ok)  rd_ptr_d = rd_next;
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            level_d = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
            // Head register tracks the oldest word so out_data never comes from a RAM mux.
            if (push_ok && (empty || (level_q == LvlW'(1) && pop_ok)))
                head_d = push_data;
            else if (pop_ok && level_q > LvlW'(1))
                head_d = mem_q[rd_next];
        end
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data  = head_q;
    assign rd_valid = valid_q;
    assign level    = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers receiver result pulses into a ready/valid stream,
// keeps sticky overrun/error/break status, sequences break recovery and enable.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DataBits = 8,
    parameter int Depth    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [DataBits-1:0]        rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_error,
    input  logic                       rx_break,
    output logic [DataBits-1:0]        out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(Depth+1)-1:0] level,
    input  logic                       status_clear,
    output logic                       overrun_flag,
    output logic                       error_flag,
    output logic                       break_flag,
    output logic                       irq
);

    if (!data_bits_legal(DataBits)) begin : g_bad_data_bits
        $error("uart_rx_ctrl: DataBits out of range");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_ctrl: Depth must be a power of two >= 2");
    end

    uart_rx_ctrl_state_t state_q, state_d;
    logic overrun_q, overrun_d;
    logic error_q, error_d;
    logic break_q, break_d;
    logic irq_q, irq_d;

    logic fifo_full, fifo_empty;
    logic fifo_flush;
    logic push_req, pop_req;
    logic overrun_set, error_set, break_set;

    always_comb begin
        state_d     = state_q;
        push_req    = 1'b0;
        error_set   = 1'b0;
        break_set   = 1'b0;
        fifo_flush  = flush || !enable || (state_q == OFF);
        pop_req     = out_ready && !fifo_empty;
        if (!enable) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: state_d = RUN;
                RUN: begin
                    if (rx_break) begin
                        break_set = 1'b1;
                        state_d   = BREAK;
                    end else if (rx_error) begin
                        error_set = 1'b1;
                    end else begin
                        push_req = rx_valid;
                    end
                end
                BREAK: begin
                    // Break and error pulses are noise until line activity resumes.
                    if (rx_valid) begin
                        push_req = 1'b1;
                        state_d  = RUN;
                    end
                end
                default: state_d = OFF;
            endcase
        end
        overrun_set = push_req && !fifo_flush && fifo_full && !pop_req;
        overrun_d   = (overrun_q && !status_clear) || overrun_set;
        error_d     = (error_q && !status_clear) || error_set;
        break_d     = (break_q && !status_clear) || break_set;
        irq_d       = out_valid || overrun_q || error_q || break_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OFF;
            overrun_q <= 1'b0;
            error_q   <= 1'b0;
            break_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            error_q   <= error_d;
            break_q   <= break_d;
            irq_q     <= irq_d;
        end
    end

    sync_fifo #(
        .Width (DataBits),
        .Depth (Depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (rx_data),
        .pop       (pop_req),
        .flush     (fifo_flush),
        .rd_data   (out_data),
        .rd_valid  (out_valid),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign overrun_flag = overrun_q;
    assign error_flag   = error_q;
    assign break_flag   = break_q;
    assign irq          = irq_q;

endmodule
